// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  // Protocol phases of the target, one per byte or acknowledge slot.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  // Level on SDA during the ninth clock of a byte.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Least significant bit of the address byte.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Pad-side I2C signals. The target sees SCL/SDA as inputs and controls
// only the SDA pull-down enable; the bus itself is open drain.
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave  (input scl_i, input sda_i, output sda_oe);
  modport master (output scl_i, output sda_i, input sda_oe);
endinterface

// File: rtl/i2c_pin_filter.sv
// Synchroniser plus majority-free run-length filter for one I2C line.
// The filtered level follows the pin only after FILT identical samples,
// so pin-to-level latency is 2 + FILT clocks and shorter glitches vanish.
module i2c_pin_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  localparam int CW = 3;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronise the pad, then accept a new level after FILT matching samples.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so the two synchroniser stages really form a two-stage pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle I2C lines are pulled high, so the filter starts there.
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
    end else begin
      // NOTE: the pad is asynchronous to clk; only sync_q[1] may be used
      // by logic, sync_q[0] is allowed to go metastable.
      sync_q <= {sync_q[0], pin};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing register file. SCL and SDA are
// oversampled on clk; a pointer byte selects the register, subsequent
// write bytes are stored and reads stream registers out, both wrapping.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h77,
  parameter int         NREGS = 8,
  parameter logic [7:0] INIT  = 8'hAA,
  parameter int         FILT  = 3,
  localparam int        PTR_W = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_target_regs_if.slave     bus,
  output logic [8*NREGS-1:0]   regs,
  output logic                 wr_stb,
  output logic [PTR_W-1:0]     wr_idx,
  output logic                 busy
);

  logic scl_f, sda_f;
  logic scl_q, sda_q;
  logic scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx_byte;

  state_t                    state;
  logic [3:0]                bit_cnt;
  logic [7:0]                shreg;
  logic [PTR_W-1:0]          ptr;
  logic                      sda_oe_q;
  logic [NREGS-1:0][7:0]     reg_q;

  i2c_pin_filter #(.FILT(FILT)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (bus.scl_i),
    .level (scl_f)
  );

  i2c_pin_filter #(.FILT(FILT)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (bus.sda_i),
    .level (sda_f)
  );

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP need SCL high in both cycles, so an SDA change coinciding
  // with an SCL edge is treated purely as the SCL edge.
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shreg[6:0], sda_f};

  assign bus.sda_oe = sda_oe_q;
  assign regs       = reg_q;

  // Protocol FSM with shift register, pointer, register file and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      sda_oe_q <= 1'b0;
      // NOTE: the register file is visible to fabric logic straight out of
      // reset, so every entry is a resettable flop rather than a RAM.
      reg_q    <= {NREGS{INIT}};
      wr_stb   <= 1'b0;
      wr_idx   <= '0;
      busy     <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      if (start_c) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_c) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        sda_oe_q <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: begin
          end

          ST_ADDR: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_byte[7:1] == ADDR) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // First fall after the byte asserts ACK, the next one ends it.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~ACK;
            end else if (shreg[0] == RW_READ) begin
              sda_oe_q <= ~reg_q[ptr][7];
              shreg    <= {reg_q[ptr][6:0], 1'b0};
              bit_cnt  <= 4'd1;
              state    <= ST_RDATA;
            end else begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_PTR;
            end
          end

          ST_PTR: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              ptr     <= rx_byte[PTR_W-1:0];
              state   <= ST_PTR_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= ~ACK;
            end else begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_WDATA;
            end
          end

          ST_WDATA: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt    <= '0;
              reg_q[ptr] <= rx_byte;
              wr_stb     <= 1'b1;
              wr_idx     <= ptr;
              ptr        <= ptr + PTR_W'(1);
              state      <= ST_WDATA_ACK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // bit_cnt counts bits already placed on SDA; after eight, release.
          ST_RDATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_RDATA_ACK;
            end else begin
              sda_oe_q <= ~shreg[7];
              shreg    <= {shreg[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end

          // bit_cnt == 1 here records that the master acknowledged.
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              ptr <= ptr + PTR_W'(1);
              if (sda_f == NACK) begin
                state <= ST_IGNORE;
              end else begin
                bit_cnt <= 4'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd1) begin
              sda_oe_q <= ~reg_q[ptr][7];
              shreg    <= {reg_q[ptr][6:0], 1'b0};
              bit_cnt  <= 4'd1;
              state    <= ST_RDATA;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
